// File: rtl/fpu_config_loader_if.sv
// -----------------------------------------------------------------------------
// fpu_config_loader_if
// Memory read channel between the configuration loader and the line-wide
// memory port. The loader holds the request (and a stable line-aligned
// address) until the memory answers with one cycle of valid data.
//
// Signals:
//   mapped_data_request  loader -> mem  read request
//   address_mem          loader -> mem  line-aligned byte address
//   mapped_data_valid    mem -> loader  read data valid (one cycle per line)
//   data_mem             mem -> loader  read data, DATA_W bits
//
// Modports: master (loader side), slave (memory side).
// -----------------------------------------------------------------------------
interface fpu_config_loader_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
);
  logic              mapped_data_request;
  logic [ADDR_W-1:0] address_mem;
  logic              mapped_data_valid;
  logic [DATA_W-1:0] data_mem;

  modport master (
    output mapped_data_request,
    output address_mem,
    input  mapped_data_valid,
    input  data_mem
  );

  modport slave (
    input  mapped_data_request,
    input  address_mem,
    output mapped_data_valid,
    output data_mem
  );
endinterface

// File: rtl/fpu_config_loader.sv
// -----------------------------------------------------------------------------
// fpu_config_loader
// Fetches a multi-line configuration record from memory on a start pulse,
// unpacks image geometry, source/result addresses and NUM_CH KxK signed 8-bit
// kernels, optionally validates them, and commits them to output registers.
//
// Optional feature macro: FPU_CFG_CHECK_EN
//   defined   -> the CHECK state flags width<K, height<K and addresses that
//                are not 4-byte aligned; a failing record is not committed.
//   undefined -> CHECK still takes one cycle, config_error stays 0 and every
//                load commits.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load_config_start   single-cycle start request (ignored unless idle)
//   config_address      record byte address; low log2(DATA_W/8) bits ignored
//   mem                 memory read channel (fpu_config_loader_if.master)
//   load_config_done    one-cycle completion pulse
//   config_error        last load failed validation; cleared by next start
//   busy                accepted start .. done pulse inclusive
//   image_width/height  committed image geometry
//   start_address       committed source address
//   result_address      committed result address
//   filter              committed coefficients, coef i at [8i+7:8i],
//                       i = ch*K*K + row*K + col
// -----------------------------------------------------------------------------
module fpu_config_loader #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32,
  parameter int K      = 3,
  parameter int NUM_CH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_config_start,
  input  logic [ADDR_W-1:0]          config_address,
  fpu_config_loader_if.master        mem,
  output logic                       load_config_done,
  output logic                       config_error,
  output logic                       busy,
  output logic [15:0]                image_width,
  output logic [15:0]                image_height,
  output logic [ADDR_W-1:0]          start_address,
  output logic [ADDR_W-1:0]          result_address,
  output logic [NUM_CH*K*K*8-1:0]    filter
);

  localparam int FILT_W     = NUM_CH * K * K * 8;
  localparam int NUM_LINES  = (128 + FILT_W + DATA_W - 1) / DATA_W;
  localparam int CNT_W      = $clog2(NUM_LINES + 1);
  localparam int LINE_BYTES = DATA_W / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int STAGE_W    = NUM_LINES * DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    line_cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic                req_r, req_nxt_s;
  logic                done_r, done_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                err_r, err_nxt_s;
  logic [STAGE_W-1:0]  staging_r;

  logic [ADDR_W-1:0]   base_s;
  logic                last_line_s;
  logic                capture_s;
  logic                check_fail_s;
  logic                commit_s;
  logic [15:0]         rec_width_s;
  logic [15:0]         rec_height_s;
  logic [31:0]         rec_start_s;
  logic [31:0]         rec_result_s;
  logic                unused_s;

`ifdef FPU_CFG_CHECK_EN
  // Record is rejected if the image is smaller than one kernel or if either
  // buffer address is not word aligned.
  function automatic logic cfg_invalid(input logic [15:0] w, input logic [15:0] h,
                                       input logic [31:0] sa, input logic [31:0] ra);
    cfg_invalid = (w < 16'(K)) || (h < 16'(K)) ||
                  (sa[1:0] != 2'b00) || (ra[1:0] != 2'b00);
  endfunction
`endif

  assign base_s       = {config_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign last_line_s  = (line_cnt_r == CNT_W'(NUM_LINES - 1));
  assign capture_s    = (state_r == REQ) && mem.mapped_data_valid;
  assign rec_width_s  = staging_r[15:0];
  assign rec_height_s = staging_r[31:16];
  assign rec_start_s  = staging_r[63:32];
  assign rec_result_s = staging_r[95:64];
`ifdef FPU_CFG_CHECK_EN
  assign check_fail_s = cfg_invalid(rec_width_s, rec_height_s, rec_start_s, rec_result_s);
`else
  assign check_fail_s = 1'b0;
`endif
  assign commit_s     = (state_r == CHECK) && !check_fail_s;
  // Reserved field and line padding are fetched but never consumed.
  assign unused_s     = ^staging_r;

  assign mem.mapped_data_request = req_r;
  assign mem.address_mem         = addr_r;
  assign load_config_done        = done_r;
  assign busy                    = busy_r;
  assign config_error            = err_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; REQ repeats once per fetched line.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (load_config_start) state_nxt_s = REQ; else state_nxt_s = IDLE;
      REQ:     if (capture_s && last_line_s) state_nxt_s = CHECK; else state_nxt_s = REQ;
      CHECK:   state_nxt_s = DONE;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered handshake/status outputs.
  always_comb begin
    req_nxt_s  = 1'b0;
    addr_nxt_s = addr_r;
    cnt_nxt_s  = line_cnt_r;
    done_nxt_s = 1'b0;
    busy_nxt_s = 1'b0;
    err_nxt_s  = err_r;
    case (state_r)
      IDLE: begin
        if (load_config_start) begin
          req_nxt_s  = 1'b1;
          addr_nxt_s = base_s;
          cnt_nxt_s  = {CNT_W{1'b0}};
          busy_nxt_s = 1'b1;
          err_nxt_s  = 1'b0;
        end else begin
          req_nxt_s  = 1'b0;
          busy_nxt_s = 1'b0;
        end
      end
      REQ: begin
        busy_nxt_s = 1'b1;
        if (capture_s && last_line_s) begin
          req_nxt_s = 1'b0;
        end else if (capture_s) begin
          req_nxt_s  = 1'b1;
          addr_nxt_s = addr_r + ADDR_W'(LINE_BYTES);
          cnt_nxt_s  = line_cnt_r + CNT_W'(1);
        end else begin
          req_nxt_s = 1'b1;
        end
      end
      CHECK: begin
        done_nxt_s = 1'b1;
        busy_nxt_s = 1'b1;
        err_nxt_s  = check_fail_s;
      end
      DONE: begin
        busy_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered outputs, line staging and commit of the validated record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r          <= 1'b0;
      addr_r         <= {ADDR_W{1'b0}};
      line_cnt_r     <= {CNT_W{1'b0}};
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
      err_r          <= 1'b0;
      staging_r      <= {STAGE_W{1'b0}};
      image_width    <= 16'd0;
      image_height   <= 16'd0;
      start_address  <= {ADDR_W{1'b0}};
      result_address <= {ADDR_W{1'b0}};
      filter         <= {FILT_W{1'b0}};
    end else begin
      req_r      <= req_nxt_s;
      addr_r     <= addr_nxt_s;
      line_cnt_r <= cnt_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
      err_r      <= err_nxt_s;
      if (capture_s) begin
        staging_r[line_cnt_r*DATA_W +: DATA_W] <= mem.data_mem;
      end
      // Commit lands on the same edge that raises done.
      if (commit_s) begin
        image_width    <= rec_width_s;
        image_height   <= rec_height_s;
        start_address  <= ADDR_W'(rec_start_s);
        result_address <= ADDR_W'(rec_result_s);
        filter         <= staging_r[128 +: FILT_W];
      end
    end
  end

endmodule

// File: tb/tb_fpu_config_loader.sv
// -----------------------------------------------------------------------------
// tb_fpu_config_loader
// Directed bench for fpu_config_loader: a default instance (K=3, NUM_CH=1,
// one line) and a K=5, NUM_CH=4 instance (two lines). The bench plays the
// memory side; expected values are hand-computed constants or derived from
// the records the bench itself builds.
// -----------------------------------------------------------------------------
module tb_fpu_config_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance
  fpu_config_loader_if #(.DATA_W(512), .ADDR_W(32)) bus_a ();
  logic        start_a = 1'b0;
  logic [31:0] cfg_a   = 32'd0;
  logic        done_a, err_a, busy_a;
  logic [15:0] w_a, h_a;
  logic [31:0] sa_a, ra_a;
  logic [71:0] filt_a;

  fpu_config_loader #(.DATA_W(512), .ADDR_W(32), .K(3), .NUM_CH(1)) dut_a (
    .clk(clk), .rst(rst), .load_config_start(start_a), .config_address(cfg_a),
    .mem(bus_a), .load_config_done(done_a), .config_error(err_a), .busy(busy_a),
    .image_width(w_a), .image_height(h_a), .start_address(sa_a),
    .result_address(ra_a), .filter(filt_a)
  );

  // K=5, NUM_CH=4 instance: 128 + 800 bits -> two 512-bit lines
  fpu_config_loader_if #(.DATA_W(512), .ADDR_W(32)) bus_b ();
  logic         start_b = 1'b0;
  logic [31:0]  cfg_b   = 32'd0;
  logic         done_b, err_b, busy_b;
  logic [15:0]  w_b, h_b;
  logic [31:0]  sa_b, ra_b;
  logic [799:0] filt_b;

  fpu_config_loader #(.DATA_W(512), .ADDR_W(32), .K(5), .NUM_CH(4)) dut_b (
    .clk(clk), .rst(rst), .load_config_start(start_b), .config_address(cfg_b),
    .mem(bus_b), .load_config_done(done_b), .config_error(err_b), .busy(busy_b),
    .image_width(w_b), .image_height(h_b), .start_address(sa_b),
    .result_address(ra_b), .filter(filt_b)
  );

  // Request rising edges and done pulses seen on each instance
  int   req_cnt_a = 0, done_cnt_a = 0, done_cnt_b = 0;
  logic req_q_a = 1'b0;
  always @(posedge clk) begin
    if (bus_a.mapped_data_request && !req_q_a) req_cnt_a <= req_cnt_a + 1;
    req_q_a <= bus_a.mapped_data_request;
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check_eq(input string tag, input logic [799:0] obs, input logic [799:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-line record, coefficients -1..7
  function automatic logic [511:0] mk_rec_a(input logic [15:0] w, input logic [15:0] h,
                                            input logic [31:0] sa, input logic [31:0] ra);
    logic [511:0] r;
    r = '0;
    r[15:0]  = w;
    r[31:16] = h;
    r[63:32] = sa;
    r[95:64] = ra;
    for (int i = 0; i < 9; i++) r[128 + 8*i +: 8] = 8'(i - 1);
    return r;
  endfunction

  // Drive one load on instance A. restart keeps start high during the first
  // REQ cycles to show it is ignored once busy.
  task automatic run_a(input string tag, input logic [31:0] addr, input logic [511:0] line,
                       input int lat, input logic [31:0] exp_addr, input bit restart);
    @(negedge clk);
    start_a = 1'b1;
    cfg_a   = addr;
    @(negedge clk);
    start_a = restart;
    check_eq({tag, "_req"}, bus_a.mapped_data_request, 1'b1);
    check_eq({tag, "_addr"}, bus_a.address_mem, exp_addr);
    check_eq({tag, "_errclr"}, err_a, 1'b0);
    repeat (lat) @(negedge clk);
    start_a = 1'b0;
    bus_a.mapped_data_valid = 1'b1;
    bus_a.data_mem = line;
    @(negedge clk);
    bus_a.mapped_data_valid = 1'b0;
    bus_a.data_mem = '0;
    check_eq({tag, "_reqdrop"}, bus_a.mapped_data_request, 1'b0);
    check_eq({tag, "_nodone_chk"}, done_a, 1'b0);
    check_eq({tag, "_busy_chk"}, busy_a, 1'b1);
    @(negedge clk);
    check_eq({tag, "_done"}, done_a, 1'b1);
    check_eq({tag, "_busy_done"}, busy_a, 1'b1);
    @(negedge clk);
    check_eq({tag, "_done_off"}, done_a, 1'b0);
    check_eq({tag, "_busy_off"}, busy_a, 1'b0);
  endtask

  // Drive one two-line load on instance B; abort asserts reset mid-REQ
  // after the first line has been returned.
  task automatic run_b(input string tag, input logic [1023:0] rec, input bit abort);
    @(negedge clk);
    start_b = 1'b1;
    cfg_b   = 32'h0000_2047;
    @(negedge clk);
    start_b = 1'b0;
    check_eq({tag, "_addr0"}, bus_b.address_mem, 32'h0000_2040);
    check_eq({tag, "_req0"}, bus_b.mapped_data_request, 1'b1);
    @(negedge clk);
    bus_b.mapped_data_valid = 1'b1;
    bus_b.data_mem = rec[511:0];
    @(negedge clk);
    bus_b.mapped_data_valid = 1'b0;
    check_eq({tag, "_req1"}, bus_b.mapped_data_request, 1'b1);
    check_eq({tag, "_addr1"}, bus_b.address_mem, 32'h0000_2080);
    if (abort) begin
      rst = 1'b1;
      #1;
      check_eq({tag, "_rst_req"}, bus_b.mapped_data_request, 1'b0);
      check_eq({tag, "_rst_busy"}, busy_b, 1'b0);
      check_eq({tag, "_rst_w"}, w_b, 16'd0);
      check_eq({tag, "_rst_filt"}, filt_b, 800'd0);
      check_eq({tag, "_rst_wa"}, w_a, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq({tag, "_rst_nodone"}, done_b, 1'b0);
      check_eq({tag, "_rst_idle"}, busy_b, 1'b0);
      check_eq({tag, "_rst_noreq"}, bus_b.mapped_data_request, 1'b0);
    end else begin
      bus_b.mapped_data_valid = 1'b1;
      bus_b.data_mem = rec[1023:512];
      @(negedge clk);
      bus_b.mapped_data_valid = 1'b0;
      check_eq({tag, "_reqdrop"}, bus_b.mapped_data_request, 1'b0);
      check_eq({tag, "_nodone_chk"}, done_b, 1'b0);
      @(negedge clk);
      check_eq({tag, "_done"}, done_b, 1'b1);
      check_eq({tag, "_err"}, err_b, 1'b0);
      @(negedge clk);
      check_eq({tag, "_done_off"}, done_b, 1'b0);
    end
  endtask

  logic [1023:0] rec_b;
  int req_before, done_before, done_b_before;

  initial begin
    bus_a.mapped_data_valid = 1'b0;
    bus_a.data_mem = '0;
    bus_b.mapped_data_valid = 1'b0;
    bus_b.data_mem = '0;
    rec_b = '0;
    rec_b[15:0]  = 16'd20;
    rec_b[31:16] = 16'd10;
    rec_b[63:32] = 32'h0000_4000;
    rec_b[95:64] = 32'h0000_5000;
    for (int i = 0; i < 100; i++) rec_b[128 + 8*i +: 8] = 8'(i + 1);

    // Reset state
    #12;
    check_eq("rst_req", bus_a.mapped_data_request, 1'b0);
    check_eq("rst_done", done_a, 1'b0);
    check_eq("rst_busy", busy_a, 1'b0);
    check_eq("rst_err", err_a, 1'b0);
    check_eq("rst_w", w_a, 16'd0);
    check_eq("rst_filt", filt_a, 72'd0);
    check_eq("rst_filt_b", filt_b, 800'd0);
    @(negedge clk);
    rst = 1'b0;

    // Nominal load, valid three cycles into the request
    run_a("t1", 32'h0000_1234, mk_rec_a(16'd640, 16'd480, 32'h0000_1000, 32'h0000_8000),
          3, 32'h0000_1200, 1'b0);
    check_eq("t1_w", w_a, 16'd640);
    check_eq("t1_h", h_a, 16'd480);
    check_eq("t1_sa", sa_a, 32'h0000_1000);
    check_eq("t1_ra", ra_a, 32'h0000_8000);
    check_eq("t1_filt", filt_a, 72'h07_06_05_04_03_02_01_00_ff);
    check_eq("t1_err", err_a, 1'b0);
    check_eq("t1_reqs", req_cnt_a, 1);
    check_eq("t1_dones", done_cnt_a, 1);

    // Valid in the very first request cycle
    run_a("t2", 32'h0000_007f, mk_rec_a(16'd100, 16'd50, 32'h0000_2000, 32'h0000_3004),
          0, 32'h0000_0040, 1'b0);
    check_eq("t2_w", w_a, 16'd100);
    check_eq("t2_h", h_a, 16'd50);
    check_eq("t2_sa", sa_a, 32'h0000_2000);
    check_eq("t2_ra", ra_a, 32'h0000_3004);

    // Width below kernel size, then misaligned start address
    run_a("t3", 32'h0000_0080, mk_rec_a(16'd2, 16'd480, 32'h0000_1000, 32'h0000_8000),
          1, 32'h0000_0080, 1'b0);
`ifdef FPU_CFG_CHECK_EN
    check_eq("t3_err", err_a, 1'b1);
    check_eq("t3_w_kept", w_a, 16'd100);
    check_eq("t3_sa_kept", sa_a, 32'h0000_2000);
`else
    check_eq("t3_err", err_a, 1'b0);
    check_eq("t3_w", w_a, 16'd2);
    check_eq("t3_sa", sa_a, 32'h0000_1000);
`endif
    run_a("t4", 32'h0000_00c0, mk_rec_a(16'd640, 16'd480, 32'h0000_1001, 32'h0000_8000),
          2, 32'h0000_00c0, 1'b0);
`ifdef FPU_CFG_CHECK_EN
    check_eq("t4_err", err_a, 1'b1);
    check_eq("t4_sa_kept", sa_a, 32'h0000_2000);
`else
    check_eq("t4_err", err_a, 1'b0);
    check_eq("t4_sa", sa_a, 32'h0000_1001);
`endif

    // Stray valid while idle, then a start re-pulsed during REQ
    @(negedge clk);
    bus_a.mapped_data_valid = 1'b1;
    bus_a.data_mem = mk_rec_a(16'd9, 16'd9, 32'h0000_0900, 32'h0000_0900);
    @(negedge clk);
    bus_a.mapped_data_valid = 1'b0;
    bus_a.data_mem = '0;
    check_eq("t5_stray_busy", busy_a, 1'b0);
    check_eq("t5_stray_req", bus_a.mapped_data_request, 1'b0);
    check_eq("t5_stray_done", done_a, 1'b0);
    req_before  = req_cnt_a;
    done_before = done_cnt_a;
    run_a("t5", 32'h0000_0100, mk_rec_a(16'd32, 16'd16, 32'h0000_0a00, 32'h0000_0b00),
          2, 32'h0000_0100, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("t5_reqs", req_cnt_a - req_before, 1);
    check_eq("t5_dones", done_cnt_a - done_before, 1);
    check_eq("t5_w", w_a, 16'd32);
    check_eq("t5_ra", ra_a, 32'h0000_0b00);

    // Two-line record on the K=5, NUM_CH=4 instance
    run_b("t6", rec_b, 1'b0);
    check_eq("t6_w", w_b, 16'd20);
    check_eq("t6_h", h_b, 16'd10);
    check_eq("t6_sa", sa_b, 32'h0000_4000);
    check_eq("t6_ra", ra_b, 32'h0000_5000);
    check_eq("t6_coef0", filt_b[7:0], 8'd1);
    check_eq("t6_coef48", filt_b[391:384], 8'd49);
    check_eq("t6_coef99", filt_b[799:792], 8'd100);
    check_eq("t6_filt", filt_b, rec_b[927:128]);

    // Reset mid-fetch, then a fresh load from line 0
    done_b_before = done_cnt_b;
    run_b("t7", rec_b, 1'b1);
    check_eq("t7_nodone_cnt", done_cnt_b - done_b_before, 0);
    run_b("t8", rec_b, 1'b0);
    check_eq("t8_coef99", filt_b[799:792], 8'd100);
    check_eq("t8_w", w_b, 16'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
